register_file_param: RTL and testbench

- Parametrised next-generation register file for the MIPS datapath.
- Configurable width, depth and read-port count.
- Adds synchronous reset, a hardwired zero register, write-to-read bypass, and a per-register busy scoreboard for the pipeline hazard unit.
- Sits between decode (reads, reservations) and writeback (writes); a separate debug port feeds the register viewer.

---
 rtl/register_file_param_if.sv | 49 ++++
 rtl/register_file_param.sv | 123 ++++++++++++
 tb/tb_register_file_param.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_param_if.sv
// Register file access bundle: decode-side reads and reservations,
// writeback-side writes, and the debug viewer read.
interface register_file_param_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 32,
    parameter int NUM_READ_PORTS = 2
);
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);

    logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] read_address;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data;
    logic [NUM_READ_PORTS-1:0]            read_busy;

    logic                  write;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0] write_data;

    logic                  reserve;
    logic [ADDR_WIDTH-1:0] reserve_address;

    logic [ADDR_WIDTH-1:0] debug_address;
    logic [DATA_WIDTH-1:0] debug_data;

    modport master (
        output read_address,
        output write,
        output write_address,
        output write_data,
        output reserve,
        output reserve_address,
        output debug_address,
        input  read_data,
        input  read_busy,
        input  debug_data
    );

    modport slave (
        input  read_address,
        input  write,
        input  write_address,
        input  write_data,
        input  reserve,
        input  reserve_address,
        input  debug_address,
        output read_data,
        output read_busy,
        output debug_data
    );
endinterface

// File: rtl/register_file_param.sv
// Parametrised register file with hardwired zero, write bypass and a
// per-register busy scoreboard for the hazard unit.
module register_file_param #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 32,
    localparam int ADDR_WIDTH    = $clog2(NUM_REGS),
    parameter int NUM_READ_PORTS = 2,
    parameter int ZERO_REG       = 1,
    parameter int BYPASS         = 1
) (
    input logic                  clk,
    input logic                  reset,
    register_file_param_if.slave bus
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;

    logic                  wr_ok;
    logic                  rs_ok;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_val;

    logic [ADDR_WIDTH-1:0] rd_addr [NUM_READ_PORTS];
    logic [DATA_WIDTH-1:0] rd_val  [NUM_READ_PORTS];
    logic                  rd_bsy  [NUM_READ_PORTS];

    // Address names a real, writable register (not out of range, not r0 when hardwired).
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic ok;
        ok = (32'(a) < 32'(NUM_REGS));
        if ((ZERO_REG != 0) && (a == '0)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    assign wr_ok    = bus.write && addr_ok(bus.write_address);
    assign rs_ok    = bus.reserve && addr_ok(bus.reserve_address);
    assign dbg_addr = bus.debug_address;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (wr_ok && (bus.write_address == ADDR_WIDTH'(r))) begin
                regs_d[r] = bus.write_data;
            end
            // A new reservation supersedes the retiring producer.
            if (rs_ok && (bus.reserve_address == ADDR_WIDTH'(r))) begin
                busy_d[r] = 1'b1;
            end else if (wr_ok && (bus.write_address == ADDR_WIDTH'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            rd_addr[p] = bus.read_address[p*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            rd_val[p] = '0;
            rd_bsy[p] = 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (rd_addr[p] == ADDR_WIDTH'(r)) begin
                    rd_val[p] = regs_q[r];
                    rd_bsy[p] = busy_q[r];
                end
            end
            if (!addr_ok(rd_addr[p])) begin
                rd_val[p] = '0;
                rd_bsy[p] = 1'b0;
            end else if ((BYPASS != 0) && bus.write &&
                         (bus.write_address == rd_addr[p])) begin
                rd_val[p] = bus.write_data;
                rd_bsy[p] = 1'b0;
            end
        end
    end

    always_comb begin
        bus.read_data = '0;
        bus.read_busy = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            bus.read_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_val[p];
            bus.read_busy[p] = rd_bsy[p];
        end
    end

    // Debug view shows committed state only, never the in-flight write.
    always_comb begin
        dbg_val = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (dbg_addr == ADDR_WIDTH'(r)) begin
                dbg_val = regs_q[r];
            end
        end
        if (!addr_ok(dbg_addr)) begin
            dbg_val = '0;
        end
    end

    assign bus.debug_data = dbg_val;

endmodule

// File: tb/tb_register_file_param.sv
// Scoreboard bench: two configurations, directed vectors plus a
// randomised stretch against a reference model on the default build.
module tb_register_file_param;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    register_file_param_if #(.DATA_WIDTH(32), .NUM_REGS(32),
                             .NUM_READ_PORTS(2)) bus_a ();
    register_file_param_if #(.DATA_WIDTH(16), .NUM_REGS(24),
                             .NUM_READ_PORTS(3)) bus_b ();

    register_file_param #(
        .DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ_PORTS(2),
        .ZERO_REG(1), .BYPASS(1)
    ) u_a (
        .clk(clk), .reset(rst_a), .bus(bus_a)
    );

    register_file_param #(
        .DATA_WIDTH(16), .NUM_REGS(24), .NUM_READ_PORTS(3),
        .ZERO_REG(0), .BYPASS(0)
    ) u_b (
        .clk(clk), .reset(rst_b), .bus(bus_b)
    );

    localparam int K_DATA = 0;
    localparam int K_BUSY = 1;
    localparam int K_DBG  = 2;

    typedef struct {
        int          cyc;
        int          dut;
        int          kind;
        int          port;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   cycle = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic expect_v(input int dut, input int kind, input int port,
                            input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = cycle;
        e.dut  = dut;
        e.kind = kind;
        e.port = port;
        e.exp  = v;
        e.name = nm;
        sbq.push_back(e);
    endtask

    function automatic logic [31:0] observe(input exp_t e);
        logic [31:0] v;
        v = '0;
        if (e.dut == 0) begin
            case (e.kind)
                K_DATA:  v = bus_a.read_data[e.port*32 +: 32];
                K_BUSY:  v = {31'b0, bus_a.read_busy[e.port]};
                default: v = bus_a.debug_data;
            endcase
        end else begin
            case (e.kind)
                K_DATA:  v = {16'b0, bus_b.read_data[e.port*16 +: 16]};
                K_BUSY:  v = {31'b0, bus_b.read_busy[e.port]};
                default: v = {16'b0, bus_b.debug_data};
            endcase
        end
        return v;
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] got;
        while (sbq.size() > 0 && sbq[0].cyc <= cycle) begin
            e = sbq.pop_front();
            total++;
            if (e.cyc < cycle) begin
                bad++;
                $display("FAIL %s: expectation from cycle %0d never checked",
                         e.name, e.cyc);
            end else begin
                got = observe(e);
                if (got !== e.exp) begin
                    bad++;
                    $display("FAIL %s: cycle %0d got %h want %h",
                             e.name, e.cyc, got, e.exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [4:0] ra0, input logic [4:0] ra1,
                           input logic wr, input logic [4:0] wa,
                           input logic [31:0] wd, input logic rs,
                           input logic [4:0] rsa, input logic [4:0] da);
        bus_a.read_address    = {ra1, ra0};
        bus_a.write           = wr;
        bus_a.write_address   = wa;
        bus_a.write_data      = wd;
        bus_a.reserve         = rs;
        bus_a.reserve_address = rsa;
        bus_a.debug_address   = da;
    endtask

    task automatic drive_b(input logic [4:0] ra0, input logic [4:0] ra1,
                           input logic [4:0] ra2, input logic wr,
                           input logic [4:0] wa, input logic [15:0] wd,
                           input logic rs, input logic [4:0] rsa,
                           input logic [4:0] da);
        bus_b.read_address    = {ra2, ra1, ra0};
        bus_b.write           = wr;
        bus_b.write_address   = wa;
        bus_b.write_data      = wd;
        bus_b.reserve         = rs;
        bus_b.reserve_address = rsa;
        bus_b.debug_address   = da;
    endtask

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // A: write and reserve r5 while in reset
        drive_a(0, 0, 1, 5, 32'hDEADBEEF, 1, 5, 0);
        step();
        rst_a = 1'b0;
        drive_a(5, 5, 0, 0, 0, 0, 0, 5);
        expect_v(0, K_DATA, 0, 32'h0, "rst_r5_d0");
        expect_v(0, K_DATA, 1, 32'h0, "rst_r5_d1");
        expect_v(0, K_BUSY, 0, 32'h0, "rst_r5_b0");
        expect_v(0, K_BUSY, 1, 32'h0, "rst_r5_b1");
        expect_v(0, K_DBG,  0, 32'h0, "rst_r5_dbg");
        step();
        drive_a(7, 7, 1, 7, 32'h12345678, 0, 0, 7);
        expect_v(0, K_DATA, 0, 32'h12345678, "byp_r7_d0");
        expect_v(0, K_DATA, 1, 32'h12345678, "byp_r7_d1");
        expect_v(0, K_DBG,  0, 32'h0,        "byp_r7_dbg_old");
        step();
        drive_a(7, 0, 0, 0, 0, 0, 0, 7);
        expect_v(0, K_DATA, 0, 32'h12345678, "r7_stored");
        expect_v(0, K_DATA, 1, 32'h0,        "r0_read");
        expect_v(0, K_DBG,  0, 32'h12345678, "r7_dbg");
        step();
        drive_a(0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0);
        expect_v(0, K_DATA, 0, 32'h0, "r0_wr_d0");
        expect_v(0, K_DATA, 1, 32'h0, "r0_wr_d1");
        expect_v(0, K_BUSY, 0, 32'h0, "r0_wr_b0");
        step();
        drive_a(0, 0, 0, 0, 0, 1, 3, 0);
        expect_v(0, K_DATA, 0, 32'h0, "r0_after_d0");
        expect_v(0, K_BUSY, 1, 32'h0, "r0_after_b1");
        expect_v(0, K_DBG,  0, 32'h0, "r0_after_dbg");
        step();
        drive_a(3, 0, 0, 0, 0, 0, 0, 0);
        expect_v(0, K_BUSY, 0, 32'h1, "r3_reserved");
        expect_v(0, K_DATA, 0, 32'h0, "r3_data0");
        expect_v(0, K_BUSY, 1, 32'h0, "r0_not_busy");
        step();
        drive_a(3, 3, 1, 3, 32'h55, 0, 0, 3);
        expect_v(0, K_DATA, 0, 32'h55, "r3_wr_byp");
        expect_v(0, K_BUSY, 0, 32'h0,  "r3_busy_forced");
        expect_v(0, K_DBG,  0, 32'h0,  "r3_dbg_nobyp");
        step();
        drive_a(3, 3, 1, 3, 32'hAA, 1, 3, 3);
        expect_v(0, K_DATA, 1, 32'hAA, "r3_rswr_byp");
        expect_v(0, K_BUSY, 0, 32'h0,  "r3_rswr_forced");
        expect_v(0, K_DBG,  0, 32'h55, "r3_dbg_55");
        step();
        drive_a(3, 3, 0, 0, 0, 1, 3, 3);
        expect_v(0, K_BUSY, 0, 32'h1,  "r3_rswr_busy");
        expect_v(0, K_BUSY, 1, 32'h1,  "r3_rswr_busy_p1");
        expect_v(0, K_DATA, 0, 32'hAA, "r3_new_data");
        expect_v(0, K_DBG,  0, 32'hAA, "r3_dbg_aa");
        step();
        drive_a(3, 9, 1, 9, 32'h99, 1, 4, 0);
        expect_v(0, K_BUSY, 0, 32'h1,  "r3_double_rs");
        expect_v(0, K_DATA, 1, 32'h99, "r9_byp");
        expect_v(0, K_BUSY, 1, 32'h0,  "r9_nonbusy_wr");
        step();
        rst_a = 1'b1;
        drive_a(4, 9, 1, 9, 32'h1, 1, 4, 9);
        expect_v(0, K_BUSY, 0, 32'h1,  "r4_busy");
        expect_v(0, K_DATA, 1, 32'h1,  "r9_byp_in_rst");
        expect_v(0, K_DBG,  0, 32'h99, "r9_dbg");
        step();
        rst_a = 1'b0;
        drive_a(4, 9, 0, 0, 0, 0, 0, 3);
        expect_v(0, K_BUSY, 0, 32'h0, "mid_rst_r4_busy");
        expect_v(0, K_DATA, 1, 32'h0, "mid_rst_r9");
        expect_v(0, K_BUSY, 1, 32'h0, "mid_rst_r9_busy");
        expect_v(0, K_DBG,  0, 32'h0, "mid_rst_r3_dbg");
        step();
        drive_a(7, 3, 0, 0, 0, 0, 0, 7);
        expect_v(0, K_DATA, 0, 32'h0, "mid_rst_r7");
        expect_v(0, K_DATA, 1, 32'h0, "mid_rst_r3");
        expect_v(0, K_DBG,  0, 32'h0, "mid_rst_r7_dbg");
        step();

        for (int r = 0; r < 32; r++) m_regs[r] = '0;
        m_busy = '0;
        for (int n = 0; n < 3000; n++) begin
            logic [4:0]  ra [2];
            logic [4:0]  wa, rsa, da;
            logic        wr, rs, rst;
            logic [31:0] wd, ev;
            for (int p = 0; p < 2; p++) begin
                ra[p] = ($urandom_range(0, 1) == 1) ?
                        5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            end
            wr  = ($urandom_range(0, 2) != 0);
            wa  = 5'($urandom_range(0, 7));
            wd  = $urandom;
            rs  = ($urandom_range(0, 2) == 0);
            rsa = 5'($urandom_range(0, 7));
            da  = 5'($urandom_range(0, 31));
            rst = ($urandom_range(0, 199) == 0);
            rst_a = rst;
            drive_a(ra[0], ra[1], wr, wa, wd, rs, rsa, da);
            for (int p = 0; p < 2; p++) begin
                if (ra[p] == 0)               ev = '0;
                else if (wr && wa == ra[p])   ev = wd;
                else                          ev = m_regs[ra[p]];
                expect_v(0, K_DATA, p, ev, "rnd_data");
                if (ra[p] == 0)               ev = '0;
                else if (wr && wa == ra[p])   ev = '0;
                else                          ev = {31'b0, m_busy[ra[p]]};
                expect_v(0, K_BUSY, p, ev, "rnd_busy");
            end
            expect_v(0, K_DBG, 0, (da == 0) ? 32'h0 : m_regs[da], "rnd_dbg");
            step();
            if (rst) begin
                for (int r = 0; r < 32; r++) m_regs[r] = '0;
                m_busy = '0;
            end else begin
                if (wr && wa != 0) m_regs[wa] = wd;
                if (wr && wa != 0) m_busy[wa] = 1'b0;
                if (rs && rsa != 0) m_busy[rsa] = 1'b1;
            end
        end
        rst_a = 1'b0;
        drive_a(0, 0, 0, 0, 0, 0, 0, 0);

        // B: 24 regs, 3 ports, 16 bit, no zero reg, no bypass
        rst_b = 1'b0;
        drive_b(23, 23, 23, 1, 23, 16'hABCD, 0, 0, 23);
        expect_v(1, K_DATA, 0, 32'h0, "b_nobyp_p0");
        expect_v(1, K_DATA, 1, 32'h0, "b_nobyp_p1");
        expect_v(1, K_DATA, 2, 32'h0, "b_nobyp_p2");
        expect_v(1, K_BUSY, 2, 32'h0, "b_rst_busy");
        expect_v(1, K_DBG,  0, 32'h0, "b_dbg_23_old");
        step();
        drive_b(27, 23, 23, 1, 27, 16'h1111, 0, 0, 27);
        expect_v(1, K_DATA, 0, 32'h0,    "b_oor_read");
        expect_v(1, K_DATA, 1, 32'hABCD, "b_r23_p1");
        expect_v(1, K_DATA, 2, 32'hABCD, "b_r23_p2");
        expect_v(1, K_DBG,  0, 32'h0,    "b_dbg_oor");
        step();
        drive_b(27, 0, 23, 1, 0, 16'hFFFF, 1, 0, 23);
        expect_v(1, K_DATA, 0, 32'h0,    "b_oor_after_wr");
        expect_v(1, K_DATA, 1, 32'h0,    "b_r0_nobyp");
        expect_v(1, K_BUSY, 1, 32'h0,    "b_r0_busy_pre");
        expect_v(1, K_DATA, 2, 32'hABCD, "b_r23_kept");
        step();
        drive_b(0, 0, 27, 0, 0, 0, 1, 27, 0);
        expect_v(1, K_DATA, 0, 32'hFFFF, "b_r0_written");
        expect_v(1, K_BUSY, 0, 32'h1,    "b_r0_rswr_busy");
        expect_v(1, K_BUSY, 2, 32'h0,    "b_oor_busy");
        expect_v(1, K_DBG,  0, 32'hFFFF, "b_r0_dbg");
        step();
        drive_b(0, 0, 27, 1, 0, 16'h1234, 0, 0, 0);
        expect_v(1, K_DATA, 0, 32'hFFFF, "b_r0_old_wr");
        expect_v(1, K_BUSY, 0, 32'h1,    "b_r0_busy_noforce");
        expect_v(1, K_BUSY, 2, 32'h0,    "b_oor_rs_ignored");
        step();
        drive_b(0, 1, 0, 1, 1, 16'h0022, 0, 0, 0);
        expect_v(1, K_DATA, 0, 32'h1234, "b_r0_new");
        expect_v(1, K_BUSY, 0, 32'h0,    "b_r0_busy_clr");
        expect_v(1, K_DATA, 1, 32'h0,    "b_r1_nobyp");
        step();
        drive_b(1, 0, 0, 0, 0, 0, 0, 0, 1);
        expect_v(1, K_DATA, 0, 32'h22, "b_r1_stored");
        expect_v(1, K_DBG,  0, 32'h22, "b_r1_dbg");
        step();
        step();
        step();

        if (sbq.size() != 0) begin
            bad += sbq.size();
            $display("FAIL leftover: %0d expectations pending, want 0",
                     sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
